// File: rtl/io_display_ctrl_if.sv
// IO bus between the MIPS core (master) and memory-mapped peripherals (slave).
interface io_display_ctrl_if;
  logic [3:0]  IOAddr;
  logic [31:0] IOWriteData;
  logic        IOWriteEn;
  logic [31:0] IOReadData;

  modport master (output IOAddr, output IOWriteData, output IOWriteEn, input IOReadData);
  modport slave  (input IOAddr, input IOWriteData, input IOWriteEn, output IOReadData);
endinterface

// File: rtl/io_display_ctrl.sv
// Memory-mapped seven-segment display refresh (NDIGITS digits, enable/blanking)
// plus synchronised, debounced slide switches with a sticky change flag.
module io_display_ctrl #(
  parameter int unsigned NDIGITS      = 4,
  parameter int unsigned REFRESH_BITS = 14,
  parameter int unsigned NSW          = 2,
  parameter int unsigned DEB_BITS     = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  io_display_ctrl_if.slave   bus,
  input  logic [NSW-1:0]     SW,
  output logic [6:0]         SEG,
  output logic [NDIGITS-1:0] AN
);
  localparam int unsigned     IDXW        = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST    = IDXW'(NDIGITS - 1);
  localparam logic [3:0]      ADDR_DATA0  = 4'h0;
  localparam logic [3:0]      ADDR_DATA1  = 4'h1;
  localparam logic [3:0]      ADDR_CTRL   = 4'h2;
  localparam logic [3:0]      ADDR_STATUS = 4'h3;

  logic [NDIGITS-1:0][6:0]  pat_q, pat_d;
  logic                     en_q, en_d;
  logic [NDIGITS-1:0]       blank_q, blank_d;
  logic [REFRESH_BITS-1:0]  ref_q, ref_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [6:0]               seg_q, seg_d;
  logic [NDIGITS-1:0]       an_q, an_d;
  logic [NSW-1:0]           sync1_q, sync2_q;
  logic [NSW-1:0]           cand_q, cand_d;
  logic [NSW-1:0]           deb_q, deb_d;
  logic [DEB_BITS-1:0]      dcnt_q, dcnt_d;
  logic                     chg_q, chg_d;
  logic                     wr_status;
  logic                     lit;
  logic [31:0]              rdata;

  // Register writes; DATA0 holds digits 0..3, DATA1 digits 4..7.
  always_comb begin
    pat_d     = pat_q;
    en_d      = en_q;
    blank_d   = blank_q;
    wr_status = 1'b0;
    if (bus.IOWriteEn) begin
      case (bus.IOAddr)
        ADDR_DATA0, ADDR_DATA1: begin
          for (int unsigned k = 0; k < NDIGITS; k++) begin
            if ((k >= 4) == bus.IOAddr[0]) pat_d[k] = bus.IOWriteData[7*(k%4) +: 7];
          end
        end
        ADDR_CTRL: begin
          en_d    = bus.IOWriteData[0];
          blank_d = bus.IOWriteData[8 +: NDIGITS];
        end
        ADDR_STATUS: wr_status = 1'b1;
        default: ;
      endcase
    end
  end

  // Refresh scan: index wraps explicitly at NDIGITS-1, not at 2^IDXW.
  always_comb begin
    ref_d = ref_q + REFRESH_BITS'(1);
    idx_d = idx_q;
    if (ref_q == '1) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
    lit   = en_q && !blank_q[idx_q];
    seg_d = lit ? ~pat_q[idx_q] : 7'h7F;
    an_d  = '1;
    if (lit) an_d[idx_q] = 1'b0;
  end

  // Shared debounce counter; a change on any switch restarts the interval.
  always_comb begin
    cand_d = cand_q;
    dcnt_d = dcnt_q;
    deb_d  = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      dcnt_d = '0;
    end else if (dcnt_q != '1) begin
      dcnt_d = dcnt_q + DEB_BITS'(1);
    end else begin
      deb_d = cand_q;
    end
    chg_d = chg_q;
    if (wr_status) chg_d = 1'b0;
    if (deb_d != deb_q) chg_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (bus.IOAddr)
      ADDR_DATA0, ADDR_DATA1: begin
        for (int unsigned k = 0; k < NDIGITS; k++) begin
          if ((k >= 4) == bus.IOAddr[0]) rdata[7*(k%4) +: 7] = pat_q[k];
        end
      end
      ADDR_CTRL: begin
        rdata[0]            = en_q;
        rdata[8 +: NDIGITS] = blank_q;
      end
      ADDR_STATUS: begin
        rdata[NSW-1:0] = deb_q;
        rdata[16]      = chg_q;
      end
      default: ;
    endcase
  end

  assign bus.IOReadData = rdata;
  assign SEG            = seg_q;
  assign AN             = an_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pat_q   <= '0;
      en_q    <= 1'b1;
      blank_q <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      en_q    <= en_d;
      blank_q <= blank_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      sync1_q <= SW;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      chg_q   <= chg_d;
    end
  end
endmodule

// File: tb/tb_io_display_ctrl.sv
// Bench for io_display_ctrl: behavioural model compared every cycle, plus
// directed vectors with literal expectations.
module tb_io_display_ctrl;
  localparam int unsigned ND = 3;
  localparam int unsigned RB = 2;
  localparam int unsigned NS = 2;
  localparam int unsigned DB = 2;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b0;
  logic [NS-1:0] SW    = '0;
  logic [6:0]    SEG;
  logic [ND-1:0] AN;
  int            checks = 0;
  int            errors = 0;

  io_display_ctrl_if bus ();

  io_display_ctrl #(.NDIGITS(ND), .REFRESH_BITS(RB), .NSW(NS), .DEB_BITS(DB)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .SW(SW), .SEG(SEG), .AN(AN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: registers, SW samples (m_hist[j] = SW seen j edges ago), cycles since reset.
  logic [6:0]    m_pat [ND];
  logic          m_en;
  logic [ND-1:0] m_blank;
  logic [NS-1:0] m_deb;
  logic          m_chg;
  logic [NS-1:0] m_hist [7];
  int unsigned   m_cyc;
  logic [6:0]    e_seg = 7'h7F;
  logic [ND-1:0] e_an  = '1;

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    logic [31:0] v = '0;
    case (a)
      4'h0: for (int k = 0; k < ND; k++) v = v | (32'(m_pat[k]) << (7*k));
      4'h2: v = 32'(m_en) | (32'(m_blank) << 8);
      4'h3: v = 32'(m_deb) | (32'(m_chg) << 16);
      default: v = '0;
    endcase
    return v;
  endfunction

  initial forever begin
    @(posedge CLK or posedge RESET);
    if (RESET) begin
      for (int k = 0; k < ND; k++) m_pat[k] = '0;
      for (int j = 0; j < 7; j++) m_hist[j] = '0;
      m_en = 1'b1; m_blank = '0; m_deb = '0; m_chg = 1'b0; m_cyc = 0;
      e_seg = 7'h7F; e_an = '1;
    end else begin
      int unsigned   idx;
      logic          stable;
      logic [NS-1:0] nd;
      // Each digit is shown for 2^RB cycles in order 0..ND-1, from the pre-edge registers.
      idx   = (m_cyc / (1 << RB)) % ND;
      e_an  = '1;
      e_seg = 7'h7F;
      if (m_en && !m_blank[idx]) begin
        e_an[idx] = 1'b0;
        e_seg     = ~m_pat[idx];
      end
      m_cyc++;
      for (int j = 6; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = SW;
      // A value is accepted once its synchronised copy has held for 2^DB+1 samples.
      stable = 1'b1;
      for (int j = 3; j <= 6; j++) if (m_hist[j] != m_hist[2]) stable = 1'b0;
      nd = stable ? m_hist[2] : m_deb;
      if (nd != m_deb) m_chg = 1'b1;
      else if (bus.IOWriteEn && bus.IOAddr == 4'h3) m_chg = 1'b0;
      m_deb = nd;
      if (bus.IOWriteEn) begin
        case (bus.IOAddr)
          4'h0: for (int k = 0; k < ND; k++) m_pat[k] = bus.IOWriteData[7*k +: 7];
          4'h2: begin m_en = bus.IOWriteData[0]; m_blank = bus.IOWriteData[8 +: ND]; end
          default: ;
        endcase
      end
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    check("model_SEG", 32'(SEG), 32'(e_seg));
    check("model_AN", 32'(AN), 32'(e_an));
    check("model_IOReadData", bus.IOReadData, exp_read(bus.IOAddr));
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.IOAddr = a; bus.IOWriteData = d; bus.IOWriteEn = 1'b1;
    @(negedge CLK);
    bus.IOWriteEn = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    @(negedge CLK);
    bus.IOAddr = a;
    #1;
    check(name, bus.IOReadData, exp);
  endtask

  logic [ND-1:0] t1_an  [12] = '{3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b101,
                                 3'b101, 3'b011, 3'b011, 3'b011, 3'b011, 3'b110};
  logic [6:0]    t1_seg [12] = '{7'h40, 7'h40, 7'h40, 7'h79, 7'h79, 7'h79,
                                 7'h79, 7'h7C, 7'h7C, 7'h7C, 7'h7C, 7'h40};

  initial begin
    int dark;
    int lit_cnt;
    int seen1;
    logic found;
    bus.IOAddr = '0; bus.IOWriteData = '0; bus.IOWriteEn = 1'b0;
    #1 RESET = 1'b1;

    // Reset values
    @(negedge CLK); #1;
    check("rst_SEG", 32'(SEG), 32'h7F);
    check("rst_AN", 32'(AN), 32'h7);
    rd(4'h0, 32'h0, "rst_DATA0");
    rd(4'h1, 32'h0, "rst_DATA1");
    rd(4'h2, 32'h1, "rst_CTRL");
    rd(4'h3, 32'h0, "rst_STATUS");

    // 1: release reset with a DATA0 write on the first edge
    @(negedge CLK);
    RESET = 1'b0;
    bus.IOAddr = 4'h0; bus.IOWriteData = 32'h0000C33F; bus.IOWriteEn = 1'b1;
    @(posedge CLK); #1;
    check("t1_first_AN", 32'(AN), 32'h6);
    check("t1_first_SEG", 32'(SEG), 32'h7F);
    @(negedge CLK);
    bus.IOWriteEn = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge CLK); #1;
      check("t1_scan_AN", 32'(AN), 32'(t1_an[n]));
      check("t1_scan_SEG", 32'(SEG), 32'(t1_seg[n]));
    end
    rd(4'h0, 32'h0000C33F, "t1_DATA0");
    wr(4'h0, 32'h000C183F);
    rd(4'h0, 32'h000C183F, "t1_DATA0_b");
    wr(4'h0, 32'hFFFFFFFF);
    rd(4'h0, 32'h001FFFFF, "t1_DATA0_unstored");
    wr(4'h1, 32'hFFFFFFFF);
    rd(4'h1, 32'h0, "t1_DATA1_absent");
    wr(4'h0, 32'h0000C33F);

    // 2: blanking and disable
    wr(4'h2, 32'h00000201);
    rd(4'h2, 32'h00000201, "t2_CTRL");
    dark = 0; seen1 = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge CLK); #1;
      if (AN == 3'b111) dark++;
      if (AN == 3'b101) seen1++;
    end
    check("t2_dark_slots", 32'(dark), 32'd4);
    check("t2_digit1_lit", 32'(seen1), 32'd0);
    wr(4'h2, 32'h0);
    rd(4'h2, 32'h0, "t2_CTRL_off");
    lit_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge CLK); #1;
      if (AN != 3'b111 || SEG != 7'h7F) lit_cnt++;
    end
    check("t2_disabled_lit", 32'(lit_cnt), 32'd0);
    wr(4'h2, 32'hFFFFFFFF);
    rd(4'h2, 32'h00000701, "t2_CTRL_mask");
    wr(4'h2, 32'h1);

    // 3: clean switch step, latency 2 + 4 + 1
    @(negedge CLK);
    SW = 2'b01; bus.IOAddr = 4'h3;
    for (int n = 1; n <= 7; n++) begin
      @(posedge CLK); #1;
      if (n == 6) check("t3_status_c6", bus.IOReadData, 32'h0);
      if (n == 7) check("t3_status_c7", bus.IOReadData, 32'h00010001);
    end
    wr(4'h3, 32'hDEADBEEF);
    rd(4'h3, 32'h00000001, "t3_chg_cleared");

    // 4: 3-cycle glitch on SW[1]
    @(negedge CLK);
    SW = 2'b11;
    repeat (3) @(negedge CLK);
    SW = 2'b01;
    for (int n = 0; n < 10; n++) begin
      @(posedge CLK); #1;
      check("t4_glitch_status", bus.IOReadData, 32'h00000001);
    end

    // 5: clear on the same edge the debounced change lands
    @(negedge CLK);
    SW = 2'b00; bus.IOAddr = 4'h3;
    repeat (6) @(negedge CLK);
    bus.IOWriteData = 32'h0; bus.IOWriteEn = 1'b1;
    @(posedge CLK); #1;
    check("t5_set_wins", bus.IOReadData, 32'h00010000);
    @(negedge CLK);
    bus.IOWriteEn = 1'b0;
    wr(4'h7, 32'hFFFFFFFF);
    rd(4'h7, 32'h0, "t5_addr7");
    rd(4'h0, 32'h0000C33F, "t5_DATA0_kept");
    rd(4'h2, 32'h00000001, "t5_CTRL_kept");
    rd(4'h3, 32'h00010000, "t5_STATUS_kept");
    rd(4'hF, 32'h0, "t5_addrF");

    // 6: asynchronous reset mid-digit-2 and mid-debounce
    wr(4'h3, 32'h0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge CLK); #1;
      if (AN == 3'b011) found = 1'b1;
    end
    check("t6_wait_digit2", 32'(found), 32'h1);
    @(negedge CLK);
    SW = 2'b10;
    repeat (3) @(negedge CLK);
    check("t6_pre_reset_AN", 32'(AN), 32'h3);
    #2 RESET = 1'b1;
    #1;
    check("t6_async_AN", 32'(AN), 32'h7);
    check("t6_async_SEG", 32'(SEG), 32'h7F);
    rd(4'h0, 32'h0, "t6_DATA0");
    rd(4'h2, 32'h1, "t6_CTRL");
    rd(4'h3, 32'h0, "t6_STATUS");
    @(negedge CLK);
    RESET = 1'b0; bus.IOAddr = 4'h3;
    for (int n = 1; n <= 7; n++) begin
      @(posedge CLK); #1;
      if (n == 6) check("t6_status_c6", bus.IOReadData, 32'h0);
      if (n == 7) check("t6_status_c7", bus.IOReadData, 32'h00010002);
    end
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
